bridge_sched: RTL

BRIDGE_SCHED -- requirements
Module: bridge_sched

---
 rtl/bridge_sched_pkg.sv | 25 ++
 rtl/bridge_sched_rr_arb2.sv | 19 +
 rtl/bridge_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bridge_sched_pkg.sv
// ---------------------------------------------------------------------------
// bridge_sched_pkg
// Shared types and constants for the bridge scheduler:
//   state_e               - scheduler FSM states
//   DRAM_AW / SD_AW       - DRAM and SD address widths
//   DATA_W                - response payload width (eight bridge bytes)
//   DEF_TIMEOUT_CYCLES    - default watchdog limit used when
//                           BRIDGE_SCHED_TIMEOUT_EN is defined
// ---------------------------------------------------------------------------
package bridge_sched_pkg;

    localparam int DRAM_AW            = 13;
    localparam int SD_AW              = 16;
    localparam int DATA_W             = 64;
    localparam int BYTES_PER_XFER     = DATA_W / 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_COLLECT = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

endpackage

// File: rtl/bridge_sched_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin grant logic (purely combinational).
//   req  [1:0] in  : request bits, bit0 = requester 0
//   last       in  : id of the requester granted most recently
//   gnt  [1:0] out : one-hot grant (all zero when no request)
// On a tie the requester that was not granted last wins; a lone requester
// always wins.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] |  last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/bridge_sched.sv
// ---------------------------------------------------------------------------
// bridge_sched
// Schedules two requesters onto a single byte-stream bridge, one transfer in
// flight at a time. FSM: IDLE -> ISSUE -> COLLECT -> RESP -> IDLE.
//
// Ports
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready [1:0]    per-requester request handshake
//   req_dir [1:0]                0 = DRAM->SD, 1 = SD->DRAM
//   req_addr_dram [1:0][12:0]    per-requester DRAM address
//   req_addr_sd   [1:0][15:0]    per-requester SD address
//   br_in_valid, br_direction,
//   br_addr_dram, br_addr_sd     bridge command (one-cycle pulse in ISSUE)
//   br_out_valid, br_out_data    bridge byte stream, MSB byte first
//   rsp_valid/rsp_ready          response handshake
//   rsp_id, rsp_data, rsp_err    response payload
//
// Handshakes: a transfer happens on a cycle where valid & ready are both 1.
// req_ready is combinational from the arbiter; rsp_valid is held with a
// stable payload until rsp_ready.
//
// Configuration: define BRIDGE_SCHED_TIMEOUT_EN to add a COLLECT watchdog
// that ends the transfer with rsp_err=1 and rsp_data=0 after TIMEOUT_CYCLES
// byte-less cycles. Without it rsp_err is tied 0 and COLLECT waits forever.
// ---------------------------------------------------------------------------
module bridge_sched
    import bridge_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_dir,
    input  logic [1:0][DRAM_AW-1:0]  req_addr_dram,
    input  logic [1:0][SD_AW-1:0]    req_addr_sd,
    output logic                     br_in_valid,
    output logic                     br_direction,
    output logic [DRAM_AW-1:0]       br_addr_dram,
    output logic [SD_AW-1:0]         br_addr_sd,
    input  logic                     br_out_valid,
    input  logic [7:0]               br_out_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err
);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                id_q, id_d;
    logic                dir_q, dir_d;
    logic [DRAM_AW-1:0]  dram_q, dram_d;
    logic [SD_AW-1:0]    sd_q, sd_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          gnt;

`ifdef BRIDGE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wdog_q, wdog_d;
    logic                err_q, err_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_q),
        .gnt  (gnt)
    );

    // Grants are only offered while idle, so at most one transfer is in flight.
    assign req_ready = (state_q == ST_IDLE) ? gnt : 2'b00;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        dir_d   = dir_q;
        dram_d  = dram_q;
        sd_d    = sd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
        wdog_d  = wdog_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|(req_valid & req_ready)) begin
                    id_d    = gnt[1];
                    dir_d   = req_dir[gnt[1]];
                    dram_d  = req_addr_dram[gnt[1]];
                    sd_d    = req_addr_sd[gnt[1]];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Everything COLLECT accumulates into is cleared on entry.
                cnt_d   = 4'd0;
                data_d  = '0;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                wdog_d  = '0;
                err_d   = 1'b0;
`endif
                state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                // A byte wins over a watchdog expiry in the same cycle.
                if (br_out_valid) begin
                    for (int k = 0; k < BYTES_PER_XFER; k++) begin
                        if (cnt_q == 4'(k)) begin
                            data_d[DATA_W-1-8*k -: 8] = br_out_data;
                        end
                    end
                    cnt_d = cnt_q + 4'd1;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (cnt_q == 4'(BYTES_PER_XFER - 1)) begin
                        state_d = ST_RESP;
                    end
                end
`ifdef BRIDGE_SCHED_TIMEOUT_EN
                else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            dir_q   <= 1'b0;
            dram_q  <= '0;
            sd_q    <= '0;
            cnt_q   <= 4'd0;
            data_q  <= '0;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            dir_q   <= dir_d;
            dram_q  <= dram_d;
            sd_q    <= sd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode registered state only; command and response fields are
    // forced to zero outside their own state.
    assign br_in_valid  = (state_q == ST_ISSUE);
    assign br_direction = br_in_valid & dir_q;
    assign br_addr_dram = br_in_valid ? dram_q : '0;
    assign br_addr_sd   = br_in_valid ? sd_q : '0;

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_id       = rsp_valid & id_q;
    assign rsp_data     = rsp_valid ? data_q : '0;
`ifdef BRIDGE_SCHED_TIMEOUT_EN
    assign rsp_err      = rsp_valid & err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule
